// File: rtl/box_sprite_engine.sv
// rtl/box_sprite_engine.sv - frame-locked multi-box sprite renderer for the VGA pixel path
module box_sprite_engine #(
    parameter int N_BOXES   = 4,
    parameter int COORD_W   = 10,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 48,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] h_count,
    input  logic [COORD_W-1:0] v_count,
    input  logic               display_en,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               pause,
    output logic               vga_r,
    output logic               vga_g,
    output logic               vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               busy
);

    localparam int IDX_W = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    localparam wide_t X_LIM = wide_t'(H_ACTIVE - BOX_W);
    localparam wide_t Y_LIM = wide_t'(V_ACTIVE - BOX_H);

    typedef enum logic {IDLE, UPD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;
    logic             start;
    logic [2:0]       rgb_d;

    coord_t x_q [N_BOXES];
    coord_t y_q [N_BOXES];
    logic   dx_neg_q [N_BOXES];
    logic   dy_neg_q [N_BOXES];

    // One axis of motion: returns {new direction is negative, new position}, reflecting at 0 and lim.
    function automatic wide_t step_axis(input coord_t pos, input logic neg, input wide_t lim);
        wide_t p;
        wide_t s;
        p = {1'b0, pos};
        s = wide_t'(STEP);
        if (!neg) begin
            if (p + s > lim) return {1'b1, lim[COORD_W-1:0]};
            else             return {1'b0, pos + coord_t'(STEP)};
        end else begin
            if (p < s)       return {1'b0, coord_t'(0)};
            else             return {1'b1, pos - coord_t'(STEP)};
        end
    endfunction

    // Widened compares so that pos+size can never wrap.
    function automatic logic in_span(input coord_t c, input coord_t lo, input int size);
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + wide_t'(size)));
    endfunction

    // Start-of-vertical-blank pulse, registered.
    always_ff @(posedge clk) begin
        if (!reset_n) tick_q <= 1'b0;
        else          tick_q <= (h_count == '0) && (v_count == coord_t'(V_ACTIVE));
    end

    // Frame divider: decides when a tick launches an update pass; ticks during a pass are dropped.
    always_comb begin
        div_d = div_q;
        start = 1'b0;
        if (tick_q && !pause && state_q == IDLE) begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d = '0;
                start = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Updater next state: walk the boxes one per clock, then return to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = UPD;
                idx_d   = '0;
            end
            UPD: if (idx_q == IDX_W'(N_BOXES - 1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Updater and divider state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
        end
    end

    // Box positions/directions: staggered start layout, moved only while the updater visits them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BOXES; i++) begin
                x_q[i]      <= coord_t'(16 + 64 * i);
                y_q[i]      <= coord_t'(16 + 48 * i);
                dx_neg_q[i] <= (i % 2) == 1;
                dy_neg_q[i] <= 1'b0;
            end
        end else if (state_q == UPD) begin
            for (int i = 0; i < N_BOXES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    {dx_neg_q[i], x_q[i]} <= step_axis(x_q[i], dx_neg_q[i], X_LIM);
                    {dy_neg_q[i], y_q[i]} <= step_axis(y_q[i], dy_neg_q[i], Y_LIM);
                end
            end
        end
    end

    // Colour select: scan from the top index down so the lowest-index hit wins.
    always_comb begin
        rgb_d = 3'b000;
        for (int i = N_BOXES - 1; i >= 0; i--) begin
            if (in_span(h_count, x_q[i], BOX_W) && in_span(v_count, y_q[i], BOX_H))
                rgb_d = 3'(i + 1);
        end
        if (!display_en) rgb_d = 3'b000;
    end

    // Output registers keep colour and syncs on the same one-cycle delay.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {vga_r, vga_g, vga_b} <= 3'b000;
            vga_hsync             <= 1'b0;
            vga_vsync             <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb_d;
            vga_hsync             <= h_sync_in;
            vga_vsync             <= v_sync_in;
        end
    end

    assign busy = (state_q == UPD);

endmodule

// File: tb/tb_box_sprite_engine.sv
// tb/tb_box_sprite_engine.sv - randomized self-checking bench for box_sprite_engine
module tb_box_sprite_engine;

    localparam int N  = 4;
    localparam int FD = 3;
    localparam int BW = 64;
    localparam int BH = 48;
    localparam int XL = 640 - BW;
    localparam int YL = 480 - BH;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] h = '0;
    logic [9:0] v = '0;
    logic       en = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       pause = 1'b0;
    logic       vga_r, vga_g, vga_b, vga_hsync, vga_vsync, busy;

    int errors = 0;
    int checks = 0;

    int mx [N];
    int my [N];
    int mdx [N];
    int mdy [N];
    int mdiv;
    int updates;

    box_sprite_engine #(
        .N_BOXES(N), .COORD_W(10), .H_ACTIVE(640), .V_ACTIVE(480),
        .BOX_W(BW), .BOX_H(BH), .STEP(1), .FRAME_DIV(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .h_count(h), .v_count(v),
        .display_en(en), .h_sync_in(hs), .v_sync_in(vs), .pause(pause),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = 16 + 64 * i;
            my[i]  = 16 + 48 * i;
            mdx[i] = (i % 2 == 1) ? -1 : 1;
            mdy[i] = 1;
        end
        mdiv = 0;
    endtask

    task automatic move_axis(inout int pos, inout int d, input int lim);
        if (d > 0) begin
            if (pos + 1 > lim) begin pos = lim; d = -1; end
            else pos = pos + 1;
        end else begin
            if (pos < 1) begin pos = 0; d = 1; end
            else pos = pos - 1;
        end
    endtask

    task automatic model_tick(input bit p, output bit upd);
        upd = 1'b0;
        if (!p) begin
            if (mdiv == FD - 1) begin
                mdiv = 0;
                upd  = 1'b1;
                for (int i = 0; i < N; i++) begin
                    move_axis(mx[i], mdx[i], XL);
                    move_axis(my[i], mdy[i], YL);
                end
            end else begin
                mdiv++;
            end
        end
    endtask

    function automatic int exp_rgb(input int hh, input int vv, input bit e);
        if (!e) return 0;
        for (int i = 0; i < N; i++)
            if (hh >= mx[i] && hh < mx[i] + BW && vv >= my[i] && vv < my[i] + BH)
                return (i + 1) % 8;
        return 0;
    endfunction

    // Drive one pixel, check colour and sync one clock later.
    task automatic probe(input int hh, input int vv, input bit e, input string name);
        int  exp;
        bit  ehs, evs;
        if (hh < 0 || vv < 0) return;
        @(negedge clk);
        h = 10'(hh); v = 10'(vv); en = e;
        ehs = 1'($urandom); evs = 1'($urandom);
        hs = ehs; vs = evs;
        exp = exp_rgb(hh, vv, e);
        @(negedge clk);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'(exp)) begin
            errors++;
            $display("FAIL %s rgb at (%0d,%0d) en=%0d: got %b want %03b", name, hh, vv, e,
                     {vga_r, vga_g, vga_b}, 3'(exp));
        end
        checks++;
        if ({vga_hsync, vga_vsync} !== {ehs, evs}) begin
            errors++;
            $display("FAIL %s sync: got %b%b want %b%b", name, vga_hsync, vga_vsync, ehs, evs);
        end
    endtask

    task automatic probe_boxes(input string name);
        for (int i = 0; i < N; i++) begin
            probe(mx[i], my[i], 1'b1, name);
            probe(mx[i] - 1, my[i], 1'b1, name);
            probe(mx[i] + BW - 1, my[i] + BH - 1, 1'b1, name);
            probe(mx[i] + BW, my[i] + BH - 1, 1'b1, name);
        end
    endtask

    // One frame tick; checks the busy pulse width against the model.
    task automatic do_tick(input bit p, output bit upd);
        int cnt;
        model_tick(p, upd);
        @(negedge clk);
        h = 10'd0; v = 10'd480; en = 1'b0; pause = p;
        @(negedge clk);
        h = 10'd1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != (upd ? N : 0)) begin
            errors++;
            $display("FAIL busy_width pause=%0d: got %0d cycles want %0d", p, cnt, upd ? N : 0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            h = 10'($urandom_range(0, 639)); v = 10'($urandom_range(0, 479));
            en = 1'b1; hs = 1'b1; vs = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, busy});
        end
        reset_n = 1'b1;
        model_reset();
        probe(16, 16, 1'b1, "reset_box0");
        probe(80, 64, 1'b1, "reset_box1");
        probe(79, 64, 1'b1, "reset_gap");
    endtask

    task automatic test_latency();
        probe(16, 16, 1'b1, "lat_box0");
        probe(80, 16, 1'b1, "lat_outside");
        probe(16, 16, 1'b0, "lat_blanked");
        probe(15, 15, 1'b1, "lat_corner_out");
    endtask

    task automatic test_motion();
        bit upd;
        for (int t = 0; t < FD; t++) do_tick(1'b0, upd);
        checks++;
        if (!(mx[0] == 17 && my[0] == 17 && mx[1] == 79 && my[1] == 65)) begin
            errors++;
            $display("FAIL motion_model: box0 (%0d,%0d) box1 (%0d,%0d) want (17,17) (79,65)",
                     mx[0], my[0], mx[1], my[1]);
        end
        probe_boxes("motion");
    endtask

    task automatic test_pause_divider();
        bit upd;
        bit pat [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int t = 0; t < 9; t++) begin
            do_tick(pat[t], upd);
            probe_boxes("pause_div");
        end
    endtask

    task automatic test_random_pixels();
        for (int k = 0; k < 40; k++)
            probe($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0), "rand_pix");
    endtask

    task automatic test_bounce_long();
        bit upd;
        int px, py;
        updates = 0;
        for (int t = 0; t < 3000 && updates < 600; t++) begin
            do_tick(1'($urandom_range(0, 7) == 0), upd);
            if (upd) begin
                updates++;
                probe_boxes("bounce");
                px = (mx[0] > mx[1]) ? mx[0] : mx[1];
                py = (my[0] > my[1]) ? my[0] : my[1];
                if (px < ((mx[0] < mx[1]) ? mx[0] : mx[1]) + BW &&
                    py < ((my[0] < my[1]) ? my[0] : my[1]) + BH)
                    probe(px, py, 1'b1, "overlap");
                probe($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, "bounce_rand");
            end
        end
        checks++;
        if (updates < 600) begin
            errors++;
            $display("FAIL bounce_updates: got %0d want 600", updates);
        end
    endtask

    task automatic test_reset_midpass();
        bit upd;
        int w;
        while (mdiv != FD - 1) do_tick(1'b0, upd);
        @(negedge clk);
        h = 10'd0; v = 10'd480; en = 1'b0; pause = 1'b0;
        @(negedge clk);
        h = 10'd1;
        w = 0;
        while (busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midpass_busy: got %b want 1", busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midpass_reset_busy: got %b want 0", busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        probe_boxes("midpass_init");
        do_tick(1'b0, upd);
        probe_boxes("midpass_div0");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_motion();
        test_pause_divider();
        test_random_pixels();
        test_bounce_long();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
